// File: rtl/dsp_pkg.sv
// Shared DSP slice definitions: post-adder opcodes and signed saturation limits.
package dsp_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Widest datapath the limit helpers can describe; callers keep the low WIDTH bits.
  localparam int MAX_W = 256;

  function automatic logic [MAX_W-1:0] sat_max(input int w);
    logic [MAX_W-1:0] one;
    one = 1;
    return (one << (w - 1)) - one;
  endfunction

  function automatic logic [MAX_W-1:0] sat_min(input int w);
    logic [MAX_W-1:0] one;
    one = 1;
    return one << (w - 1);
  endfunction

endpackage

// File: rtl/post_add_sub_core.sv
// Combinational post-adder/subtracter with signed overflow detect and optional clamp.
module post_add_sub_core
  import dsp_pkg::*;
#(
  parameter int WIDTH = 48
) (
  input  logic [WIDTH-1:0] z,
  input  logic [WIDTH-1:0] x,
  input  logic             cin,
  input  logic             sub,
  input  logic             sat_en,
  output logic [WIDTH-1:0] r,
  output logic             c,
  output logic             ovf
);

  localparam logic [MAX_W-1:0] SMAX_L = sat_max(WIDTH);
  localparam logic [MAX_W-1:0] SMIN_L = sat_min(WIDTH);
  localparam logic [WIDTH-1:0] SMAX   = SMAX_L[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SMIN   = SMIN_L[WIDTH-1:0];

  logic [WIDTH+1:0] sz, sx, ex;

  // Exact signed result: two guard bits hold every sum/difference of the operands.
  assign sz = {{2{z[WIDTH-1]}}, z};
  assign sx = {{2{x[WIDTH-1]}}, x} + (WIDTH+2)'(cin);
  assign ex = (sub == OP_SUB) ? sz - sx : sz + sx;

  assign ovf = (ex[WIDTH+1] != ex[WIDTH]) || (ex[WIDTH] != ex[WIDTH-1]);

  // The unsigned WIDTH+1 result differs from the signed one only by the two
  // sign-extension terms at bit WIDTH, so one adder yields both views.
  assign c = ex[WIDTH] ^ z[WIDTH-1] ^ x[WIDTH-1];

  always_comb begin
    r = ex[WIDTH-1:0];
    if (sat_en && ovf) r = ex[WIDTH+1] ? SMIN : SMAX;
  end

endmodule

// File: rtl/post_add_sub_acc.sv
// Pipelined post-adder/subtracter with accumulate, saturation and sticky overflow.
module post_add_sub_acc
  import dsp_pkg::*;
#(
  parameter int WIDTH   = 48,
  parameter int OUT_REG = 1,
  parameter int SAT_EN  = 0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CE,
  input  logic             IN_VALID,
  input  logic             SUB,
  input  logic             ACC_EN,
  input  logic             ACC_CLR,
  input  logic             CIN,
  input  logic [WIDTH-1:0] IN0,
  input  logic [WIDTH-1:0] IN1,
  output logic [WIDTH-1:0] OUT,
  output logic             CARRYOUT,
  output logic             OVF,
  output logic             OVF_STICKY,
  output logic             OUT_VALID
);

  localparam int STAGES = 1 + OUT_REG;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             co;
    logic             ovf;
  } stage_t;

  logic [STAGES:1] vld_q;
  logic [STAGES:0] vld_pipe;
  stage_t          st1;
  stage_t          st_out;
  logic            sticky_q;
  logic [WIDTH-1:0] z, r;
  logic            c, ovf;

  assign vld_pipe = {vld_q, IN_VALID};

  always_comb begin
    z = IN0;
    if (ACC_CLR)     z = '0;
    else if (ACC_EN) z = st1.res;
  end

  post_add_sub_core #(.WIDTH(WIDTH)) u_core (
    .z      (z),
    .x      (IN1),
    .cin    (CIN),
    .sub    (SUB),
    .sat_en (SAT_EN != 0),
    .r      (r),
    .c      (c),
    .ovf    (ovf)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_q <= '0;
    end else if (CE) begin
      vld_q <= vld_pipe[STAGES-1:0];
    end
  end

  // Stage 1 doubles as the accumulator; it only moves on qualified operands.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st1      <= '0;
      sticky_q <= 1'b0;
    end else if (CE) begin
      if (IN_VALID) begin
        st1      <= '{res: r, co: c, ovf: ovf};
        sticky_q <= (ACC_CLR ? 1'b0 : sticky_q) | ovf;
      end else if (ACC_CLR) begin
        sticky_q <= 1'b0;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)  st_out <= '0;
        else if (CE) st_out <= st1;
      end
    end else begin : g_noreg
      assign st_out = st1;
    end
  endgenerate

  assign OUT        = st_out.res;
  assign CARRYOUT   = st_out.co;
  assign OVF        = st_out.ovf;
  assign OUT_VALID  = vld_pipe[STAGES];
  assign OVF_STICKY = sticky_q;

endmodule

// File: tb/tb_post_add_sub_acc.sv
// Scoreboard bench: wrap and saturating instances (WIDTH=8, OUT_REG=1) share stimulus.
module tb_post_add_sub_acc;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         CE = 1'b0, IN_VALID = 1'b0, SUB = 1'b0, ACC_EN = 1'b0, ACC_CLR = 1'b0, CIN = 1'b0;
  logic [W-1:0] IN0 = '0, IN1 = '0;
  logic [W-1:0] out_w, out_s;
  logic         co_w, co_s, ovf_w, ovf_s, stk_w, stk_s, v_w, v_s;

  post_add_sub_acc #(.WIDTH(W), .OUT_REG(1), .SAT_EN(0)) u_wrap (
    .CLK(CLK), .RST_N(RST_N), .CE(CE), .IN_VALID(IN_VALID), .SUB(SUB), .ACC_EN(ACC_EN),
    .ACC_CLR(ACC_CLR), .CIN(CIN), .IN0(IN0), .IN1(IN1), .OUT(out_w), .CARRYOUT(co_w),
    .OVF(ovf_w), .OVF_STICKY(stk_w), .OUT_VALID(v_w));

  post_add_sub_acc #(.WIDTH(W), .OUT_REG(1), .SAT_EN(1)) u_sat (
    .CLK(CLK), .RST_N(RST_N), .CE(CE), .IN_VALID(IN_VALID), .SUB(SUB), .ACC_EN(ACC_EN),
    .ACC_CLR(ACC_CLR), .CIN(CIN), .IN0(IN0), .IN1(IN1), .OUT(out_s), .CARRYOUT(co_s),
    .OVF(ovf_s), .OVF_STICKY(stk_s), .OUT_VALID(v_s));

  always #5 CLK = ~CLK;

  typedef struct {
    int         due;
    logic [7:0] rw, rs;
    logic       cw, cs, ow, os;
  } exp_t;

  exp_t q[$];
  exp_t last;
  bit   last_v = 0;
  int   n_chk = 0, n_fail = 0;
  int   ce_cnt = 0;
  bit   ce_edge = 0;
  bit   mon_en = 0;
  int   acc_w = 0, acc_s = 0;
  bit   m_stk_w = 0, m_stk_s = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: exact integer arithmetic on the operand values.
  function automatic void ref_op(input int z, input int x, input int cin, input bit sub,
                                 input bit sat, output int r, output bit c, output bit ovf);
    int sz, sx, e, u;
    sz  = (z >= 128) ? z - 256 : z;
    sx  = (x >= 128) ? x - 256 : x;
    e   = sub ? sz - (sx + cin) : sz + sx + cin;
    u   = sub ? z - (x + cin) : z + x + cin;
    ovf = (e > 127) || (e < -128);
    c   = (u & 256) != 0;
    r   = (sat && ovf) ? ((e > 0) ? 127 : 128) : (u & 255);
  endfunction

  task automatic cyc(input bit ce, input bit vld, input bit sub, input bit acc_en,
                     input bit acc_clr, input bit cin, input logic [7:0] in0, input logic [7:0] in1);
    exp_t e;
    int   zw, zs, rw, rs;
    bit   cw, cs, ow, os;
    CE = ce; IN_VALID = vld; SUB = sub; ACC_EN = acc_en; ACC_CLR = acc_clr;
    CIN = cin; IN0 = in0; IN1 = in1;
    @(posedge CLK);
    ce_edge = ce && RST_N;
    if (ce && RST_N) begin
      ce_cnt++;
      if (vld) begin
        zw = acc_clr ? 0 : (acc_en ? acc_w : int'(in0));
        zs = acc_clr ? 0 : (acc_en ? acc_s : int'(in0));
        ref_op(zw, int'(in1), int'(cin), sub, 1'b0, rw, cw, ow);
        ref_op(zs, int'(in1), int'(cin), sub, 1'b1, rs, cs, os);
        e.due = ce_cnt + 1;
        e.rw = 8'(rw); e.rs = 8'(rs); e.cw = cw; e.cs = cs; e.ow = ow; e.os = os;
        q.push_back(e);
        acc_w = rw; acc_s = rs;
        m_stk_w = (acc_clr ? 1'b0 : m_stk_w) | ow;
        m_stk_s = (acc_clr ? 1'b0 : m_stk_s) | os;
      end else if (acc_clr) begin
        m_stk_w = 0; m_stk_s = 0;
      end
    end
    #1;
    chk("sticky_wrap", 32'(stk_w), 32'(m_stk_w));
    chk("sticky_sat",  32'(stk_s), 32'(m_stk_s));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
  endtask

  // Monitor: every fresh CE edge either presents the head of the queue or nothing.
  always @(negedge CLK) begin
    exp_t e;
    if (mon_en && RST_N) begin
      if (ce_edge) begin
        if (q.size() > 0 && q[0].due == ce_cnt) begin
          e = q.pop_front();
          chk("valid_wrap", 32'(v_w), 32'd1);
          chk("valid_sat",  32'(v_s), 32'd1);
          chk("out_wrap",   32'(out_w), 32'(e.rw));
          chk("out_sat",    32'(out_s), 32'(e.rs));
          chk("cout_wrap",  32'(co_w), 32'(e.cw));
          chk("cout_sat",   32'(co_s), 32'(e.cs));
          chk("ovf_wrap",   32'(ovf_w), 32'(e.ow));
          chk("ovf_sat",    32'(ovf_s), 32'(e.os));
          last = e; last_v = 1;
        end else begin
          chk("idle_valid_wrap", 32'(v_w), 32'd0);
          chk("idle_valid_sat",  32'(v_s), 32'd0);
          last_v = 0;
        end
      end else begin
        chk("hold_valid_wrap", 32'(v_w), 32'(last_v));
        chk("hold_valid_sat",  32'(v_s), 32'(last_v));
        if (last_v) begin
          chk("hold_out_wrap", 32'(out_w), 32'(last.rw));
          chk("hold_out_sat",  32'(out_s), 32'(last.rs));
          chk("hold_ovf_wrap", 32'(ovf_w), 32'(last.ow));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] edge_v [0:5];
    edge_v[0] = 8'h00; edge_v[1] = 8'h7F; edge_v[2] = 8'h80;
    edge_v[3] = 8'hFF; edge_v[4] = 8'h01; edge_v[5] = 8'h40;

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_out",    32'(out_w | out_s), 32'd0);
    chk("rst_valid",  32'(v_w | v_s), 32'd0);
    chk("rst_sticky", 32'(stk_w | stk_s), 32'd0);
    chk("rst_cout",   32'(co_w | co_s | ovf_w | ovf_s), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    mon_en = 1;

    // Basic add with carry-in, then subtract through zero
    cyc(1, 1, 0, 0, 0, 1, 8'h10, 8'h05);
    idle(3);
    cyc(1, 1, 1, 0, 0, 0, 8'h03, 8'h05);
    idle(3);

    // Positive overflow, then ACC_CLR forces Z to zero and clears the sticky flag
    cyc(1, 1, 0, 0, 0, 0, 8'h70, 8'h20);
    cyc(1, 1, 0, 0, 1, 0, 8'h01, 8'h01);
    idle(3);

    // Accumulate 1..5, stall one cycle, continue
    cyc(1, 1, 0, 0, 1, 0, 8'h00, 8'h01);
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 1, 0, 0, 8'h00, 8'h01);
    cyc(0, 1, 0, 1, 0, 0, 8'h00, 8'h01);
    cyc(0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    cyc(1, 1, 0, 1, 0, 0, 8'h00, 8'h01);
    idle(3);

    // Wrapping accumulation across the signed boundary
    cyc(1, 1, 0, 0, 1, 0, 8'h00, 8'h40);
    cyc(1, 1, 0, 1, 0, 0, 8'h00, 8'h40);
    cyc(1, 1, 0, 1, 0, 0, 8'h00, 8'h40);
    idle(3);

    // IN1 all-ones with CIN subtracts 2^WIDTH; most-negative minus one
    cyc(1, 1, 1, 0, 0, 1, 8'h00, 8'hFF);
    cyc(1, 1, 1, 0, 0, 1, 8'h80, 8'h00);
    cyc(1, 0, 0, 0, 1, 0, 8'h00, 8'h00);
    idle(3);

    // Randomised traffic with stalls, gaps, clears and corner operands
    for (int i = 0; i < 400; i++) begin
      logic [7:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 5)] : 8'($urandom);
      b = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 5)] : 8'($urandom);
      cyc($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, 1'($urandom),
          1'($urandom), $urandom_range(0, 15) == 0, 1'($urandom), a, b);
    end
    idle(3);

    // Asynchronous reset with an overflowing op held between the two stages
    cyc(1, 1, 0, 0, 0, 0, 8'h7F, 8'h01);
    #2;
    RST_N = 1'b0;
    #1;
    chk("async_out",    32'(out_w | out_s), 32'd0);
    chk("async_valid",  32'(v_w | v_s), 32'd0);
    chk("async_sticky", 32'(stk_w | stk_s), 32'd0);
    q.delete();
    acc_w = 0; acc_s = 0; m_stk_w = 0; m_stk_s = 0; last_v = 0;
    cyc(1, 1, 0, 0, 0, 0, 8'h55, 8'h11);
    @(negedge CLK);
    RST_N = 1'b1;
    idle(4);

    // Post-reset accumulator starts from zero
    cyc(1, 1, 0, 1, 0, 0, 8'hAA, 8'h03);
    idle(3);

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
